// File: rtl/hdmi_info_frame_pkg.sv
// Shared types and constants for the HDMI InfoFrame builder.
package hdmi_info_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int MAX_PAYLOAD = 27;

    localparam logic [6:0] AVI   = 7'd2;
    localparam logic [6:0] SPD   = 7'd3;
    localparam logic [6:0] AUDIO = 7'd4;

endpackage

// File: rtl/info_frame_checksum_acc.sv
// Sequential mod-256 byte accumulator; the checksum output is its two's complement.
module info_frame_checksum_acc (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_add,
    input  logic [7:0] i_add_val,
    output logic [7:0] o_checksum
);

    logic [7:0] r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= 8'd0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_add) begin
            r_acc <= r_acc + i_add_val;
        end
    end

    assign o_checksum = 8'd0 - r_acc;

endmodule

// File: rtl/info_frame_builder.sv
// Double-buffered InfoFrame builder: software fills a shadow payload, commit checksums it,
// and the packet scheduler's swap strobe publishes it into the active buffer.
module info_frame_builder
    import hdmi_info_frame_pkg::*;
#(
    parameter logic [6:0] INFO_TYPE = 7'd3,
    parameter logic [7:0] VERSION   = 8'd1,
    parameter logic [4:0] LENGTH    = 5'd25
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             commit,
    input  logic             swap,
    output logic             pending,
    output logic             valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    generate
        if (LENGTH < 5'd1 || int'(LENGTH) > MAX_PAYLOAD) begin : g_bad_length
            $error("info_frame_builder: LENGTH must be in 1..27");
        end
    endgenerate

    localparam logic [7:0] HB0     = {1'b1, INFO_TYPE};
    localparam logic [7:0] HB1     = VERSION;
    localparam logic [7:0] HB2     = {3'b000, LENGTH};
    localparam logic [7:0] HDR_SUM = HB0 + HB1 + HB2;

    state_e     r_state;
    state_e     w_next;
    logic [4:0] r_idx;
    logic [4:0] w_idx_next;
    logic       w_load;
    logic       w_add;
    logic       w_publish;
    logic       w_wr_ok;
    logic [7:0] w_checksum;
    logic       r_valid;

    // Index 0 and indices above LENGTH are never written, so they stay zero.
    logic [7:0] r_shadow [0:31];
    logic [7:0] r_active [0:MAX_PAYLOAD];

    assign header   = {HB2, HB1, HB0};
    assign wr_ready = (r_state == IDLE);
    assign pending  = (r_state == PEND);
    assign valid    = r_valid;
    assign w_wr_ok  = wr_en && (r_state == IDLE) && (wr_addr != 5'd0) && (wr_addr <= LENGTH);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) r_shadow[i] <= 8'd0;
        end else if (w_wr_ok) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
        end
    end

    // SUM spends LENGTH cycles adding bytes plus one closing cycle at index LENGTH+1.
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_load     = 1'b0;
        w_add      = 1'b0;
        w_publish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (commit) begin
                    w_next     = SUM;
                    w_load     = 1'b1;
                    w_idx_next = 5'd1;
                end
            end
            SUM: begin
                if (r_idx == LENGTH + 5'd1) begin
                    w_next = PEND;
                end else begin
                    w_add      = 1'b1;
                    w_idx_next = r_idx + 5'd1;
                end
            end
            PEND: begin
                if (swap) begin
                    w_publish = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    info_frame_checksum_acc u_acc (
        .i_clk      (clk_pixel),
        .i_rst_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (HDR_SUM),
        .i_add      (w_add),
        .i_add_val  (r_shadow[r_idx]),
        .o_checksum (w_checksum)
    );

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= MAX_PAYLOAD; i++) r_active[i] <= 8'd0;
            r_valid <= 1'b0;
        end else if (w_publish) begin
            r_active[0] <= w_checksum;
            for (int i = 1; i <= MAX_PAYLOAD; i++) r_active[i] <= r_shadow[i];
            r_valid <= 1'b1;
        end
    end

    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sub[i][8*j +: 8] = r_active[7*i + j];
            end
        end
    end

endmodule

// File: tb/tb_info_frame_builder.sv
// Self-checking bench for info_frame_builder: vector table plus hand-written corner sequences.
module tb_info_frame_builder;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic             a_wr_en, a_commit, a_swap;
    logic [4:0]       a_wr_addr;
    logic [7:0]       a_wr_data;
    logic             a_wr_ready, a_pending, a_valid;
    logic [23:0]      a_header;
    logic [3:0][55:0] a_sub;

    // LENGTH=13, INFO_TYPE=2, VERSION=2 instance
    logic             b_wr_en, b_commit, b_swap;
    logic [4:0]       b_wr_addr;
    logic [7:0]       b_wr_data;
    logic             b_wr_ready, b_pending, b_valid;
    logic [23:0]      b_header;
    logic [3:0][55:0] b_sub;

    info_frame_builder u_dut (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .wr_ready  (a_wr_ready),
        .commit    (a_commit),
        .swap      (a_swap),
        .pending   (a_pending),
        .valid     (a_valid),
        .header    (a_header),
        .sub       (a_sub)
    );

    info_frame_builder #(.INFO_TYPE(7'd2), .VERSION(8'd2), .LENGTH(5'd13)) u_dut13 (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .wr_ready  (b_wr_ready),
        .commit    (b_commit),
        .swap      (b_swap),
        .pending   (b_pending),
        .valid     (b_valid),
        .header    (b_header),
        .sub       (b_sub)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   m_shadow [0:27];
    logic [223:0] sb_q [$];
    logic [223:0] last_frame;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp_pb0;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [223:0] model_frame();
        logic [223:0] f = '0;
        logic [7:0]   s = 8'h83 + 8'h01 + 8'h19;
        for (int k = 1; k <= 27; k++) begin
            f[8*k +: 8] = m_shadow[k];
            s = s + m_shadow[k];
        end
        f[7:0] = 8'd0 - s;
        return f;
    endfunction

    function automatic logic [7:0] byte_sum(input logic [23:0] h, input logic [223:0] f);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < 3; i++) s = s + h[8*i +: 8];
        for (int k = 0; k < 28; k++) s = s + f[8*k +: 8];
        return s;
    endfunction

    task automatic a_write(input logic [4:0] addr, input logic [7:0] data, input bit model_it);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
        if (model_it && addr >= 5'd1 && addr <= 5'd25) m_shadow[addr] = data;
    endtask

    task automatic a_wait_pending(input int start, input string name);
        int lat = start;
        while (!a_pending && lat < 100) begin
            tick();
            lat++;
        end
        check(name, lat, 26);
    endtask

    task automatic a_commit_wait(input string name);
        a_commit = 1'b1;
        sb_q.push_back(model_frame());
        tick();
        a_commit = 1'b0;
        a_wait_pending(0, name);
    endtask

    task automatic a_swap_check(input string name);
        logic [223:0] exp;
        a_swap = 1'b1;
        tick();
        a_swap = 1'b0;
        check({name, "_valid"}, a_valid, 1'b1);
        check({name, "_pending"}, a_pending, 1'b0);
        check({name, "_wr_ready"}, a_wr_ready, 1'b1);
        if (sb_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 1'b1, 1'b0);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_frame"}, a_sub, exp);
        end
        check({name, "_bytesum"}, byte_sum(a_header, a_sub), 8'd0);
        last_frame = a_sub;
    endtask

    initial begin
        logic [223:0] f13;
        int lat;

        vecs[0] = '{1'b0, 5'd0,  8'h00, 8'h63};
        vecs[1] = '{1'b1, 5'd1,  8'h41, 8'h22};
        vecs[2] = '{1'b1, 5'd0,  8'h55, 8'h22};
        vecs[3] = '{1'b1, 5'd26, 8'hAA, 8'h22};
        vecs[4] = '{1'b1, 5'd31, 8'hFF, 8'h22};
        vecs[5] = '{1'b1, 5'd25, 8'h10, 8'h12};
        vecs[6] = '{1'b1, 5'd7,  8'h01, 8'h11};
        vecs[7] = '{1'b0, 5'd0,  8'h00, 8'h11};

        for (int k = 0; k < 28; k++) m_shadow[k] = 8'd0;
        last_frame = '0;
        {a_wr_en, a_commit, a_swap, a_wr_addr, a_wr_data} = '0;
        {b_wr_en, b_commit, b_swap, b_wr_addr, b_wr_data} = '0;

        reset_n = 1'b0;
        #23;
        check("reset_pending", a_pending, 1'b0);
        check("reset_valid", a_valid, 1'b0);
        check("reset_sub", a_sub, '0);
        check("header", a_header, 24'h190183);
        reset_n = 1'b1;
        tick();
        check("reset_wr_ready", a_wr_ready, 1'b1);

        // Table-driven write/commit/swap sequences, shadow persisting across vectors
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].we) a_write(vecs[v].addr, vecs[v].data, 1'b1);
            a_commit_wait($sformatf("vec%0d_latency", v));
            a_swap_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d_pb0", v), a_sub[0][7:0], vecs[v].exp_pb0);
        end
        check("pb1_is_41", a_sub[0][15:8], 8'h41);
        check("pb26_zero", a_sub[3][47:40], 8'h00);
        check("pb27_zero", a_sub[3][55:48], 8'h00);

        // commit and swap during SUM, write and commit during PEND: all ignored
        a_write(5'd2, 8'h5A, 1'b1);
        a_commit = 1'b1;
        sb_q.push_back(model_frame());
        tick();
        a_commit = 1'b0;
        tick(); tick(); tick();
        a_swap = 1'b1;
        tick();
        a_swap = 1'b0;
        check("sum_swap_active", a_sub, last_frame);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        check("sum_commit_active", a_sub, last_frame);
        a_wait_pending(5, "sum_pulses_latency");
        check("pend_wr_ready", a_wr_ready, 1'b0);
        a_write(5'd2, 8'h99, 1'b0);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        tick();
        check("pend_still_pending", a_pending, 1'b1);
        check("pend_active", a_sub, last_frame);
        a_swap_check("pend_swap");
        check("pend_swap_pb0", a_sub[0][7:0], 8'hB7);

        // Reset asserted mid-SUM aborts; later swaps publish nothing
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        tick(); tick(); tick(); tick();
        reset_n = 1'b0;
        #2;
        check("abort_valid", a_valid, 1'b0);
        check("abort_pending", a_pending, 1'b0);
        check("abort_sub", a_sub, '0);
        for (int k = 0; k < 28; k++) m_shadow[k] = 8'd0;
        #4;
        reset_n = 1'b1;
        tick();
        check("abort_wr_ready", a_wr_ready, 1'b1);
        for (int p = 0; p < 3; p++) begin
            a_swap = 1'b1;
            tick();
            a_swap = 1'b0;
            tick();
        end
        check("abort_swap_valid", a_valid, 1'b0);
        check("abort_swap_pending", a_pending, 1'b0);
        check("abort_swap_sub", a_sub, '0);
        a_commit_wait("after_reset_latency");
        a_swap_check("after_reset");
        check("after_reset_pb0", a_sub[0][7:0], 8'h63);

        // Non-default parameters: LENGTH=13, all payload bytes 0x01
        check("b_header", b_header, 24'h0D0282);
        for (int k = 1; k <= 13; k++) begin
            b_wr_en   = 1'b1;
            b_wr_addr = 5'(k);
            b_wr_data = 8'h01;
            tick();
        end
        b_wr_en   = 1'b0;
        b_commit  = 1'b1;
        tick();
        b_commit = 1'b0;
        lat = 0;
        while (!b_pending && lat < 100) begin
            tick();
            lat++;
        end
        check("b_latency", lat, 14);
        b_swap = 1'b1;
        tick();
        b_swap = 1'b0;
        f13 = '0;
        f13[7:0] = 8'h62;
        for (int k = 1; k <= 13; k++) f13[8*k +: 8] = 8'h01;
        check("b_valid", b_valid, 1'b1);
        check("b_pb0", b_sub[0][7:0], 8'h62);
        check("b_frame", b_sub, f13);
        check("b_bytesum", byte_sum(b_header, b_sub), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/info_frame_builder.md
INFO_FRAME_BUILDER -- requirements
Module: info_frame_builder

Interface
REQ-001 SHALL have parameter INFO_TYPE, default 7'd3: InfoFrame type code, 0x80 | INFO_TYPE forms header byte HB0.
REQ-002 SHALL have parameter VERSION, default 8'd1: header byte HB1.
REQ-003 SHALL have parameter LENGTH, default 5'd25: payload length in bytes, legal range 1..27; values outside this range SHALL fail elaboration.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports clk_pixel and reset_n.
REQ-005 Ports (name, direction, width, meaning):
- clk_pixel, in, 1: pixel clock.
- reset_n, in, 1: async active-low reset.
- wr_en, in, 1: shadow payload byte write strobe.
- wr_addr, in, 5: payload byte index PBn.
- wr_data, in, 8: payload byte value.
- wr_ready, out, 1: shadow buffer accepts writes and commit.
- commit, in, 1: single-cycle request to checksum and publish the shadow buffer.
- swap, in, 1: packet-boundary strobe from the packet scheduler; the active packet may change.
- pending, out, 1: checksummed frame waiting for swap.
- valid, out, 1: the active frame holds published content.
- header, out, 24: {3'b0,LENGTH}, VERSION, {1'b1,INFO_TYPE}.
- sub[3:0], out, 56 each: active packet subpackets.

Function
REQ-006 header SHALL be constant; HB0 in bits [7:0].
REQ-007 wr_en with wr_ready=1 and 1<=wr_addr<=LENGTH SHALL write wr_data to shadow PB[wr_addr] at the clock edge; wr_addr 0, wr_addr>LENGTH, and wr_en with wr_ready=0 SHALL be ignored.
REQ-008 PB[LENGTH+1..27] SHALL always read as 8'h00 in both buffers.
REQ-009 State machine SHALL have states IDLE, SUM and PEND; wr_ready SHALL be 1 only in IDLE.
REQ-010 In IDLE, commit SHALL cause a transition to SUM and load the accumulator with (HB0+HB1+HB2) mod 256; commit and wr_en in the same cycle SHALL apply the write first, so the new byte is included.
REQ-011 SUM SHALL add one shadow byte per cycle, PB1..PB[LENGTH] in order, mod 256, lasting exactly LENGTH cycles, then transition to PEND with checksum = (256 - acc) mod 256.
REQ-012 Latency: commit sampled at edge 0 SHALL give pending=1 after edge LENGTH+1.
REQ-013 In PEND, swap=1 SHALL, in one edge, copy shadow PB1..27 and the checksum (as PB0) into the active buffer, set valid=1, clear pending, and return to IDLE.
REQ-014 commit during SUM or PEND SHALL be ignored; swap during IDLE or SUM SHALL have no effect; the active buffer SHALL change only per REQ-013.
REQ-015 sub[i] SHALL be {PB[7i+6],...,PB[7i]} of the active buffer, with PB[7i] in bits [7:0].
REQ-016 Invariant: once valid=1, HB0+HB1+HB2+PB0+...+PB27 ≡ 0 mod 256.
REQ-017 Shadow contents SHALL persist after swap, so a repeat commit with no writes reproduces the same frame.

Reset
REQ-018 reset_n=0 SHALL, asynchronously, set state to IDLE, clear the accumulator and both buffers to zero, and drive wr_ready=1 on release, pending=0, valid=0 and sub=0; header stays constant.
REQ-019 Reset asserted during SUM or PEND SHALL abort the computation, and no swap SHALL occur afterwards until a new commit completes.

Structure
REQ-020 Package hdmi_info_frame_pkg SHALL hold the state enum, constant MAX_PAYLOAD=27, and type codes AVI=2, SPD=3, AUDIO=4.
REQ-021 Sub-module info_frame_checksum_acc (sequential mod-256 accumulator with load, add and two's-complement result) SHALL be instantiated once.

Verification
REQ-022 Bench SHALL cover: defaults, no writes, commit, then swap in PEND -> pending after 26 edges; sub[0][7:0]=8'h63; valid=1; all other bytes 0.
REQ-023 Bench SHALL cover: write PB1=8'h41, commit, swap -> PB0=8'h22, sub[0][15:8]=8'h41, and the byte sum of the frame ≡ 0.
REQ-024 Bench SHALL cover: writes to wr_addr 0, 26 and 31 with LENGTH=25 -> no change; PB26 and PB27 stay 0.
REQ-025 Bench SHALL cover: commit and swap pulsed during SUM, plus a write during PEND -> all ignored; active buffer unchanged until a swap in PEND.
REQ-026 Bench SHALL cover: reset_n low mid-SUM, then swap pulses -> valid=0, pending=0, sub=0, and no publication.
REQ-027 Bench SHALL cover: LENGTH=13, INFO_TYPE=2, VERSION=2, all payload bytes 8'h01 -> PB0=(256-(0x82+0x02+0x0D+13)) mod 256=8'h62.
